// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared types and constants for the OrangeCrab LED / button block.
//   - led_mode_e : per-channel drive mode (off, solid, blink, breathe)
//   - LED_OFF    : led_n level that keeps an LED dark (outputs are active-low)
// ---------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_SOLID   = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

   localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser plus stability counter for the raw user button.
//   The debounced level only follows the synchronised input after it has
//   disagreed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
//
//   clk48       in   system clock
//   rst_n       in   synchronous reset, active-low
//   usr_btn     in   raw button, low = pressed, asynchronous
//   btn_pressed out  debounced level, high = pressed
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic clk48,
   input  logic rst_n,
   input  logic usr_btn,
   output logic btn_pressed
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sync_pressed;
   logic [DW-1:0] cnt;
   logic          pressed_q;

   // Synchroniser resets to "released" so a reset never fakes a press.
   assign sync_pressed = ~sync_q[1];
   assign btn_pressed  = pressed_q;

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         cnt       <= '0;
         pressed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], usr_btn};
         if (sync_pressed != pressed_q) begin
            if (cnt == CNT_LAST) begin
               pressed_q <= sync_pressed;
               cnt       <= '0;
            end else begin
               cnt <= cnt + DW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// rgb_pwm_ctrl
//   Multi-channel PWM LED driver with per-channel off/solid/blink/breathe
//   modes, a single-slot config port applied at PWM period boundaries, and a
//   debounced user button that raises a sticky bootloader request after a
//   long press.
//
//   Build option: define LED_GAMMA_EN for square-law duty correction
//   (one extra register stage, led_n latency 2 instead of 1).
//
//   clk48       in   48 MHz system clock
//   rst_n       in   synchronous reset, active-low
//   cfg_valid   in   config request
//   cfg_ready   out  config accepted when cfg_valid && cfg_ready
//   cfg_chan    in   target channel; out-of-range channels are swallowed
//   cfg_mode    in   led_mode_e encoding
//   cfg_level   in   brightness
//   led_n       out  LED drive, active-low
//   usr_btn     in   raw button, low = pressed, asynchronous
//   btn_pressed out  debounced button, high = pressed
//   boot_req_n  out  sticky bootloader request, active-low
// ---------------------------------------------------------------------------
module rgb_pwm_ctrl
   import led_pkg::*;
#(
   parameter int CHANNELS        = 3,
   parameter int PWM_BITS        = 8,
   parameter int STEP_CYCLES     = 187500,
   parameter int DEBOUNCE_CYCLES = 480000,
   parameter int LONGPRESS_STEPS = 256
) (
   input  logic                                               clk48,
   input  logic                                               rst_n,
   input  logic                                               cfg_valid,
   output logic                                               cfg_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
   input  logic [1:0]                                         cfg_mode,
   input  logic [PWM_BITS-1:0]                                cfg_level,
   output logic [CHANNELS-1:0]                                led_n,
   input  logic                                               usr_btn,
   output logic                                               btn_pressed,
   output logic                                               boot_req_n
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int HW = $clog2(LONGPRESS_STEPS + 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
   localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [HW-1:0]       HOLD_MAX  = HW'(LONGPRESS_STEPS);

   typedef struct packed {
      logic [CW-1:0]       chan;
      led_mode_e           mode;
      logic [PWM_BITS-1:0] level;
   } cfg_req_t;

   // ---------------- timebase: PWM counter, step tick, triangle ramp
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [SW-1:0]       step_cnt;
   logic                step_tick;
   logic [PWM_BITS-1:0] ramp;
   logic                dir;

   assign step_tick = (step_cnt == STEP_LAST);

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         pwm_cnt  <= '0;
         step_cnt <= '0;
         ramp     <= '0;
         dir      <= 1'b0;
      end else begin
         pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
         step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
         // At either end the ramp dwells for one tick while dir flips.
         if (step_tick) begin
            if (!dir) begin
               if (ramp == PWM_MAX) dir  <= 1'b1;
               else                 ramp <= ramp + PWM_BITS'(1);
            end else begin
               if (ramp == '0)      dir  <= 1'b0;
               else                 ramp <= ramp - PWM_BITS'(1);
            end
         end
      end
   end

   // ---------------- config port: one pending slot, applied on wrap
   cfg_req_t                          pend;
   logic                              pend_vld;
   logic                              pend_vld_nxt;
   logic                              cfg_ready_q;
   logic                              cfg_fire;
   logic                              boundary;
   logic [CHANNELS-1:0][1:0]          mode_q;
   logic [CHANNELS-1:0][PWM_BITS-1:0] level_q;

   assign cfg_ready = cfg_ready_q;
   assign cfg_fire  = cfg_valid && cfg_ready_q;
   assign boundary  = (pwm_cnt == PWM_MAX);

   // A request taken on the boundary cycle cannot also be applied on it:
   // ready implies the slot was empty, so it waits a full period.
   always_comb begin
      pend_vld_nxt = pend_vld;
      if (cfg_fire)      pend_vld_nxt = 1'b1;
      else if (boundary) pend_vld_nxt = 1'b0;
   end

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         pend        <= '0;
         pend_vld    <= 1'b0;
         cfg_ready_q <= 1'b0;
         mode_q      <= '0;
         level_q     <= '0;
      end else begin
         pend_vld    <= pend_vld_nxt;
         cfg_ready_q <= ~pend_vld_nxt;
         if (cfg_fire) begin
            pend.chan  <= cfg_chan;
            pend.mode  <= led_mode_e'(cfg_mode);
            pend.level <= cfg_level;
         end
         if (boundary && pend_vld) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (pend.chan == CW'(i)) begin
                  mode_q[i]  <= pend.mode;
                  level_q[i] <= pend.level;
               end
            end
         end
      end
   end

   // ---------------- per-channel duty
   logic [CHANNELS-1:0][PWM_BITS-1:0] duty;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [PWM_BITS-1:0] breathe;
      logic [PWM_BITS-1:0] duty_c;

      // Keep the top half of the full-width product (truncate, no rounding).
      assign breathe = PWM_BITS'(({{PWM_BITS{1'b0}}, ramp} *
                                  {{PWM_BITS{1'b0}}, level_q[i]}) >> PWM_BITS);

      always_comb begin
         duty_c = '0;
         unique case (led_mode_e'(mode_q[i]))
            MODE_OFF:     duty_c = '0;
            MODE_SOLID:   duty_c = level_q[i];
            MODE_BLINK:   duty_c = dir ? '0 : level_q[i];
            MODE_BREATHE: duty_c = breathe;
            default:      duty_c = '0;
         endcase
      end

      assign duty[i] = duty_c;
   end

   // ---------------- optional gamma stage, then comparator
   logic [PWM_BITS-1:0]               cmp_cnt;
   logic [CHANNELS-1:0][PWM_BITS-1:0] cmp_duty;

`ifdef LED_GAMMA_EN
   logic [CHANNELS-1:0][PWM_BITS-1:0] duty_sq;
   logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q;
   logic [PWM_BITS-1:0]               pwm_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_gamma
      assign duty_sq[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, duty[i]} *
                                     {{PWM_BITS{1'b0}}, duty[i]}) >> PWM_BITS);
   end

   // pwm_cnt is delayed alongside duty so both reach the comparator together.
   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         duty_q <= '0;
         pwm_q  <= '0;
      end else begin
         duty_q <= duty_sq;
         pwm_q  <= pwm_cnt;
      end
   end

   assign cmp_cnt  = pwm_q;
   assign cmp_duty = duty_q;
`else
   assign cmp_cnt  = pwm_cnt;
   assign cmp_duty = duty;
`endif

   logic [CHANNELS-1:0] lit;
   logic [CHANNELS-1:0] led_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
      assign lit[i] = (cmp_cnt < cmp_duty[i]);
   end

   always_ff @(posedge clk48) begin
      if (!rst_n) led_q <= {CHANNELS{LED_OFF}};
      else        led_q <= ~lit;
   end

   assign led_n = led_q;

   // ---------------- button, long-press hold counter, bootloader request
   logic [HW-1:0] hold_cnt;
   logic          boot_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk48       (clk48),
      .rst_n       (rst_n),
      .usr_btn     (usr_btn),
      .btn_pressed (btn_pressed)
   );

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         boot_q   <= 1'b1;
      end else begin
         if (!btn_pressed)
            hold_cnt <= '0;
         else if (step_tick && hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + HW'(1);
         // Sticky: only reset can raise it again.
         if (hold_cnt == HOLD_MAX) boot_q <= 1'b0;
      end
   end

   assign boot_req_n = boot_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
module tb_rgb_pwm_ctrl;

   localparam int CH  = 3;
   localparam int PB  = 4;
   localparam int SC  = 2;
   localparam int DC  = 4;
   localparam int LP  = 8;
   localparam int PER = 1 << PB;
`ifdef LED_GAMMA_EN
   localparam int LAT   = 2;
   localparam bit GAMMA = 1'b1;
`else
   localparam int LAT   = 1;
   localparam bit GAMMA = 1'b0;
`endif

   logic          clk48 = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [1:0]    cfg_chan = '0;
   logic [1:0]    cfg_mode = '0;
   logic [PB-1:0] cfg_level = '0;
   logic          usr_btn = 1'b1;
   logic          cfg_ready;
   logic [CH-1:0] led_n;
   logic          btn_pressed;
   logic          boot_req_n;

   rgb_pwm_ctrl #(
      .CHANNELS(CH), .PWM_BITS(PB), .STEP_CYCLES(SC),
      .DEBOUNCE_CYCLES(DC), .LONGPRESS_STEPS(LP)
   ) dut (
      .clk48(clk48), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
      .led_n(led_n), .usr_btn(usr_btn), .btn_pressed(btn_pressed),
      .boot_req_n(boot_req_n)
   );

   always #5 clk48 = ~clk48;

   // Reference model: transaction log of accepted configs plus closed-form
   // timebase (cycle n after release has pwm = n mod 2^PB, n/SC step ticks).
   typedef struct { int acc; int app; int ch; int mode; int lvl; } ev_t;
   ev_t evq[$];
   bit  raw_q[$];
   int  n = 0;
   bit  model_on = 1'b0;
   bit  m_p = 1'b0;
   int  m_hold = 0;
   bit  m_boot_n = 1'b1;
   int  n_chk = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
   endtask

   function automatic bit exp_ready(int c);
      if (c < 1) return 1'b0;
      foreach (evq[k]) if (evq[k].acc <= c && c < evq[k].app) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int duty_at(int ch, int c);
      int md = 0, lv = 0, ph, rmp, d;
      bit dn;
      foreach (evq[k]) if (evq[k].ch == ch && evq[k].app <= c) begin
         md = evq[k].mode;
         lv = evq[k].lvl;
      end
      ph  = (c / SC) % (2 * PER);
      dn  = (ph >= PER);
      rmp = dn ? (2 * PER - 1 - ph) : ph;
      case (md)
         1:       d = lv;
         2:       d = dn ? 0 : lv;
         3:       d = (rmp * lv) >> PB;
         default: d = 0;
      endcase
      if (GAMMA) d = (d * d) >> PB;
      return d;
   endfunction

   function automatic logic [CH-1:0] exp_led(int c);
      logic [CH-1:0] r = '1;
      int pc;
      if (c < LAT) return r;
      pc = c - LAT;
      for (int i = 0; i < CH; i++) r[i] = !((pc % PER) < duty_at(i, pc));
      return r;
   endfunction

   function automatic bit raw_at(int j);
      if (j < 1) return 1'b0;
      return raw_q[j-1];
   endfunction

   task automatic model_step();
      bit flip;
      if (!rst_n) begin
         n = 0; evq.delete(); raw_q.delete();
         m_p = 1'b0; m_hold = 0; m_boot_n = 1'b1;
      end else begin
         if (cfg_valid && exp_ready(n))
            evq.push_back('{acc: n + 1, app: ((n + 1) / PER + 1) * PER, ch: int'(cfg_chan),
                            mode: int'(cfg_mode), lvl: int'(cfg_level)});
         n++;
         raw_q.push_back(!usr_btn);
         if (m_hold == LP) m_boot_n = 1'b0;
         if (!m_p) m_hold = 0;
         else if (n % SC == 0 && m_hold < LP) m_hold++;
         // Debounced level flips once the last DC synchronised samples
         // (two cycles old) all disagree with it.
         flip = 1'b1;
         for (int k = 2; k < DC + 2; k++) if (raw_at(n - k) == m_p) flip = 1'b0;
         if (flip) m_p = !m_p;
      end
      model_on = 1'b1;
   endtask

   initial forever begin
      @(posedge clk48);
      model_step();
   end

   initial forever begin
      @(negedge clk48);
      if (model_on) begin
         chk("cfg_ready",   cfg_ready,   exp_ready(n));
         chk("led_n",       led_n,       exp_led(n));
         chk("btn_pressed", btn_pressed, m_p);
         chk("boot_req_n",  boot_req_n,  m_boot_n);
      end
   end

   task automatic idle(input int k);
      repeat (k) @(negedge clk48);
   endtask

   task automatic drive_cfg(input int ch, input int md, input int lv);
      cfg_valid = 1'b1;
      cfg_chan  = 2'(ch);
      cfg_mode  = 2'(md);
      cfg_level = PB'(lv);
      @(negedge clk48);
      cfg_valid = 1'b0;
   endtask

   task automatic send(input int ch, input int md, input int lv);
      int w = 0;
      while (!cfg_ready && w < 64) begin @(negedge clk48); w++; end
      if (w >= 64) chk("cfg_ready_timeout", cfg_ready, 1);
      else drive_cfg(ch, md, lv);
   endtask

   // Present a request exactly on the pwm_cnt = all-ones cycle.
   task automatic race_send(input int ch, input int md, input int lv);
      int w = 0;
      while (!(cfg_ready && (n % PER) == PER - 1) && w < 64) begin @(negedge clk48); w++; end
      if (w >= 64) chk("race_timeout", cfg_ready, 1);
      else drive_cfg(ch, md, lv);
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(20);

      send(0, 1, 4);          idle(40);
      race_send(1, 1, 9);     idle(40);
      send(1, 3, 15);
      send(2, 2, 8);          idle(140);
      send(0, 1, 8);          idle(40);
      send(3, 1, 15);         idle(20);

      repeat (12) begin
         send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, PER - 1));
         idle($urandom_range(0, 40));
      end

      // bounce every 2 cycles: never long enough to register
      for (int i = 0; i < 12; i++) begin usr_btn = ~usr_btn; idle(2); end
      usr_btn = 1'b1;  idle(12);
      // roughly 7 steps of hold: short of a long press
      usr_btn = 1'b0;  idle(7 * SC);
      usr_btn = 1'b1;  idle(12);
      // long press, then release: request must stick
      usr_btn = 1'b0;  idle(DC + 2 + (LP + 2) * SC);
      usr_btn = 1'b1;  idle(20);

      repeat (10) begin
         usr_btn = 1'($urandom_range(0, 1));
         idle($urandom_range(1, 12));
      end
      usr_btn = 1'b1;  idle(10);

      // reset while an update is pending
      send(2, 1, 15);
      rst_n = 1'b0;    idle(2);
      rst_n = 1'b1;    idle(40);

      repeat (6) begin
         send($urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(1, PER - 1));
         usr_btn = 1'($urandom_range(0, 1));
         idle($urandom_range(5, 30));
      end
      usr_btn = 1'b0;  idle(DC + 2 + (LP + 2) * SC);
      usr_btn = 1'b1;  idle(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
- Multi-channel LED driver for the OrangeCrab top level, fed by the 48 MHz board clock.
- Each channel is an independent PWM output with a per-channel mode: off, solid, blink or breathe.
- Per-channel settings are loaded through a valid/ready config port and applied glitch-free at PWM period boundaries.
- Also debounces the user button and raises a sticky bootloader request after a long press.

Parameters:
CHANNELS, 3, number of LED channels (r, g, b).
PWM_BITS, 8, duty resolution; PWM period = 2^PWM_BITS clk48 cycles.
STEP_CYCLES, 187500, clk48 cycles per breathe/blink step (3.9 ms).
DEBOUNCE_CYCLES, 480000, cycles the raw button must be stable before the debounced level changes (10 ms).
LONGPRESS_STEPS, 256, steps the debounced button must be held to request the bootloader.

Ports:
clk48  in  1  system clock, 48 MHz.
rst_n  in  1  synchronous reset, active-low.
cfg_valid  in  1  config request.
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
cfg_chan  in  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are accepted and ignored.
cfg_mode  in  2  0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE.
cfg_level  in  PWM_BITS  brightness.
led_n  out  CHANNELS  LED drive, active-low (1 = dark).
usr_btn  in  1  raw button, low = pressed, asynchronous to clk48.
btn_pressed  out  1  debounced button, high = pressed.
boot_req_n  out  1  bootloader request, active-low, sticky; drives the top-level rst_n.

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on the clk48 rising edge.
  - While rst_n = 0: led_n = all 1, cfg_ready = 0, btn_pressed = 0, boot_req_n = 1.
  - Also while rst_n = 0: all modes OFF, levels 0, pending update cleared, all counters 0.
- Config port:
  - cfg_ready rises on the first cycle after rst_n goes high.
  - On acceptance, the request is latched into a single pending slot and cfg_ready drops on the next cycle.
- PWM timing:
  - A free-running counter pwm_cnt (PWM_BITS wide) wraps at all-ones.
  - On the edge where pwm_cnt = all-ones, the pending entry is copied into the channel's active mode/level.
  - cfg_ready returns to 1 on the following cycle.
  - An acceptance on the boundary cycle itself waits for the next boundary.
  - A new level never takes effect mid-period.
- Step and ramp:
  - step_cnt counts 0..STEP_CYCLES-1; a step tick occurs on its wrap.
  - ramp (PWM_BITS wide) and dir (1 bit) form a triangle: ramp increments on ticks while dir = 0, decrements while dir = 1.
  - dir toggles on the tick where ramp reaches all-ones or zero; ramp holds that value for that tick.
- Duty per channel:
  - OFF: 0.
  - SOLID: level.
  - BLINK: dir ? 0 : level.
  - BREATHE: (ramp * level) >> PWM_BITS.
  - Product width is 2*PWM_BITS with no rounding.
- Output:
  - Channel lit when pwm_cnt < duty, so maximum brightness is (2^PWM_BITS - 1)/2^PWM_BITS.
  - led_n is registered: one cycle latency from pwm_cnt.
- Button:
  - usr_btn passes through a 2-flop synchroniser.
  - btn_pressed changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - While btn_pressed = 1, a hold counter increments on step ticks, saturating at LONGPRESS_STEPS.
  - boot_req_n goes 0 on the cycle after the count reaches LONGPRESS_STEPS and stays 0 until reset.
  - Release clears the hold counter.
- Reset mid-operation: the pending update is discarded and LEDs go dark on the next edge.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: final duty = (duty * duty) >> PWM_BITS, i.e. square-law perceptual correction, applied after mode selection, one extra register stage.
  - led_n latency becomes 2 cycles.
  - The config boundary behaviour is unchanged.
- Undefined: linear duty, latency 1.

Decomposition:
- Package led_pkg:
  - 2-bit mode typedef with MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BREATHE.
  - LED_OFF constant = 1'b1.
- Sub-module btn_debounce: synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES, output btn_pressed.
- Everything else stays in rgb_pwm_ctrl.

Test Plan:
All scenarios use PWM_BITS=4, STEP_CYCLES=2, DEBOUNCE_CYCLES=4, LONGPRESS_STEPS=8.
- Reset: rst_n=0 for 3 cycles -> led_n=3'b111, cfg_ready=0, boot_req_n=1; rst_n=1 -> cfg_ready=1 after 1 cycle.
- SOLID: chan 0, level 4 -> from the next period, led_n[0]=0 for exactly 4 of 16 cycles (pwm_cnt 0..3, seen one cycle late); cfg_ready low until the boundary.
- Boundary race: request accepted on the pwm_cnt=15 cycle -> applied only at the next wrap, 16 cycles later.
- BREATHE: chan 1, level 15 -> duty follows (ramp*15)>>4 through ramp 0..15..0; BLINK: chan 2, level 8 -> duty 8 while dir=0, 0 while dir=1.
- Button: bounce usr_btn 1/0 every 2 cycles -> btn_pressed stays 0; hold low -> btn_pressed=1 after 2+4 cycles; hold 8 steps -> boot_req_n=0 and sticky after release; release at 7 steps -> boot_req_n stays 1.
- LED_GAMMA_EN: SOLID level 8 -> duty 4 (8*8>>4), latency 2.
